// File: rtl/serial_frame_deser_if.sv
// Bit-stream input and word valid/ready output bundle for serial_frame_deser.
// The master side drives the serial bits and dout_ready; the slave side is the deserializer.
interface serial_frame_deser_if #(
   parameter int unsigned WIDTH = 8
);
   logic             i;
   logic             e;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             sof;
   logic             locked;
   logic             overflow;

   modport master (
      output i, e, dout_ready,
      input  dout, dout_valid, sof, locked, overflow
   );

   modport slave (
      input  i, e, dout_ready,
      output dout, dout_valid, sof, locked, overflow
   );
endinterface

// File: rtl/serial_frame_deser.sv
// Hunts a strobed serial stream for a sync word, then deserializes FRAME_WORDS words
// per frame into a one-deep valid/ready holding register.
module serial_frame_deser #(
   parameter int unsigned       WIDTH       = 8,
   parameter int unsigned       SYNC_W      = 8,
   parameter logic [SYNC_W-1:0] SYNC        = 8'hA5,
   parameter int unsigned       FRAME_WORDS = 4
) (
   input logic                 clk,
   input logic                 rst,
   serial_frame_deser_if.slave bus
);

   localparam int unsigned BIT_CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned WORD_CW = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;

   typedef enum logic {
      S_HUNT    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t              r_state;
   logic [SYNC_W-2:0]   r_win;
   logic [WIDTH-2:0]    r_acc;
   logic [BIT_CW-1:0]   r_bit_cnt;
   logic [WORD_CW-1:0]  r_word_cnt;
   logic [WIDTH-1:0]    r_dout;
   logic                r_valid;
   logic                r_sof;
   logic                r_ovf;

   state_t              w_state_nxt;
   logic [SYNC_W-2:0]   w_win_nxt;
   logic [WIDTH-2:0]    w_acc_nxt;
   logic [BIT_CW-1:0]   w_bit_cnt_nxt;
   logic [WORD_CW-1:0]  w_word_cnt_nxt;
   logic [WIDTH-1:0]    w_dout_nxt;
   logic                w_valid_nxt;
   logic                w_sof_nxt;
   logic                w_ovf_nxt;

   // Only the oldest SYNC_W-1 / WIDTH-1 bits are stored; the live bit completes the window or word.
   logic [SYNC_W-1:0]   w_window;
   logic [WIDTH-1:0]    w_word;

   assign w_window = {r_win, bus.i};
   assign w_word   = {r_acc, bus.i};

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_HUNT;
         r_win      <= '0;
         r_acc      <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_dout     <= '0;
         r_valid    <= 1'b0;
         r_sof      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_win      <= w_win_nxt;
         r_acc      <= w_acc_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_word_cnt <= w_word_cnt_nxt;
         r_dout     <= w_dout_nxt;
         r_valid    <= w_valid_nxt;
         r_sof      <= w_sof_nxt;
         r_ovf      <= w_ovf_nxt;
      end
   end

   // Next-state, sync hunt, word assembly and holding-register control
   always_comb begin
      w_state_nxt    = r_state;
      w_win_nxt      = r_win;
      w_acc_nxt      = r_acc;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_word_cnt_nxt = r_word_cnt;
      w_dout_nxt     = r_dout;
      w_valid_nxt    = r_valid;
      w_sof_nxt      = r_sof;
      w_ovf_nxt      = 1'b0;

      if (r_valid && bus.dout_ready) begin
         w_valid_nxt = 1'b0;
      end

      if (bus.e) begin
         unique case (r_state)
            S_HUNT: begin
               if (w_window == SYNC) begin
                  w_state_nxt    = S_COLLECT;
                  w_win_nxt      = '0;
                  w_bit_cnt_nxt  = '0;
                  w_word_cnt_nxt = '0;
               end else begin
                  w_win_nxt = w_window[SYNC_W-2:0];
               end
            end
            S_COLLECT: begin
               w_acc_nxt = w_word[WIDTH-2:0];
               if (r_bit_cnt == BIT_CW'(WIDTH - 1)) begin
                  // Load when the hold is empty or being drained on this same edge
                  if (!r_valid || bus.dout_ready) begin
                     w_dout_nxt  = w_word;
                     w_valid_nxt = 1'b1;
                     w_sof_nxt   = (r_word_cnt == '0);
                  end else begin
                     w_ovf_nxt = 1'b1;
                  end
                  w_bit_cnt_nxt = '0;
                  if (r_word_cnt == WORD_CW'(FRAME_WORDS - 1)) begin
                     w_state_nxt    = S_HUNT;
                     w_word_cnt_nxt = '0;
                  end else begin
                     w_word_cnt_nxt = r_word_cnt + WORD_CW'(1);
                  end
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_CW'(1);
               end
            end
            default: begin
               w_state_nxt = S_HUNT;
            end
         endcase
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_valid;
   assign bus.sof        = r_sof;
   assign bus.overflow   = r_ovf;
   assign bus.locked     = (r_state == S_COLLECT);

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser: sync hunt, gapped strobes, full frames,
// backpressure/overflow, false sync and asynchronous abort.
module tb_serial_frame_deser;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   serial_frame_deser_if #(.WIDTH(8)) bus ();

   serial_frame_deser #(
      .WIDTH      (8),
      .SYNC_W     (8),
      .SYNC       (8'hA5),
      .FRAME_WORDS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Send the n low bits of v MSB first; each strobed bit is preceded by gap-1 idle cycles
   task automatic send_bits(input logic [15:0] v, input int n, input int gap);
      for (int k = n - 1; k >= 0; k--) begin
         for (int g = 1; g < gap; g++) begin
            bus.e = 1'b0;
            bus.i = 1'b0;
            step();
         end
         bus.e = 1'b1;
         bus.i = v[k];
         step();
      end
      bus.e = 1'b0;
      bus.i = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.e = 1'b0;
      bus.i = 1'b0;
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst            = 1'b1;
      bus.i          = 1'b0;
      bus.e          = 1'b0;
      bus.dout_ready = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_valid",  32'(bus.dout_valid), 32'h0);
      chk("rst_locked", 32'(bus.locked),     32'h0);
      chk("rst_ovf",    32'(bus.overflow),   32'h0);
      chk("rst_sof",    32'(bus.sof),        32'h0);
      chk("rst_dout",   32'(bus.dout),       32'h0);

      // Sync then one word, strobe every cycle
      bus.dout_ready = 1'b1;
      send_bits(16'h0052, 7, 1);
      chk("t2_prelock", 32'(bus.locked), 32'h0);
      send_bits(16'h0001, 1, 1);
      chk("t2_lock", 32'(bus.locked), 32'h1);
      send_bits(16'h003C, 8, 1);
      chk("t2_dout",  32'(bus.dout),       32'h3C);
      chk("t2_sof",   32'(bus.sof),        32'h1);
      chk("t2_valid", 32'(bus.dout_valid), 32'h1);

      // Asynchronous reset mid-cycle with a word held and the frame open
      bus.dout_ready = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("t1_valid",  32'(bus.dout_valid), 32'h0);
      chk("t1_locked", 32'(bus.locked),     32'h0);
      chk("t1_ovf",    32'(bus.overflow),   32'h0);
      chk("t1_sof",    32'(bus.sof),        32'h0);
      step();
      rst = 1'b0;
      idle(1);
      chk("t1_hunt", 32'(bus.locked), 32'h0);

      // Same stream with a strobe every third cycle
      bus.dout_ready = 1'b1;
      send_bits(16'h00A5, 8, 3);
      chk("t3_lock", 32'(bus.locked), 32'h1);
      send_bits(16'h001E, 7, 3);
      idle(2);
      chk("t3_notyet", 32'(bus.dout_valid), 32'h0);
      send_bits(16'h0000, 1, 1);
      chk("t3_valid", 32'(bus.dout_valid), 32'h1);
      chk("t3_dout",  32'(bus.dout),       32'h3C);
      chk("t3_sof",   32'(bus.sof),        32'h1);
      do_reset();

      // Full frame then a stray word while hunting
      bus.dout_ready = 1'b1;
      send_bits(16'h00A5, 8, 1);
      send_bits(16'h0001, 8, 1);
      chk("t4_w1", 32'(bus.dout), 32'h01);
      chk("t4_s1", 32'(bus.sof),  32'h1);
      send_bits(16'h0002, 8, 1);
      chk("t4_w2", 32'(bus.dout), 32'h02);
      chk("t4_s2", 32'(bus.sof),  32'h0);
      send_bits(16'h0003, 8, 1);
      chk("t4_w3", 32'(bus.dout), 32'h03);
      chk("t4_l3", 32'(bus.locked), 32'h1);
      send_bits(16'h0004, 8, 1);
      chk("t4_w4",    32'(bus.dout),       32'h04);
      chk("t4_s4",    32'(bus.sof),        32'h0);
      chk("t4_v4",    32'(bus.dout_valid), 32'h1);
      chk("t4_unlck", 32'(bus.locked),     32'h0);
      send_bits(16'h0001, 8, 1);
      chk("t4_stray_v", 32'(bus.dout_valid), 32'h0);
      chk("t4_stray_l", 32'(bus.locked),     32'h0);
      chk("t4_stray_d", 32'(bus.dout),       32'h04);
      do_reset();

      // Backpressure: second word dropped with a single overflow pulse
      bus.dout_ready = 1'b0;
      send_bits(16'h00A5, 8, 1);
      send_bits(16'h0011, 8, 1);
      chk("t5_d11", 32'(bus.dout),       32'h11);
      chk("t5_v11", 32'(bus.dout_valid), 32'h1);
      send_bits(16'h0022, 8, 1);
      chk("t5_ovf",  32'(bus.overflow),   32'h1);
      chk("t5_hold", 32'(bus.dout),       32'h11);
      chk("t5_sof",  32'(bus.sof),        32'h1);
      chk("t5_vh",   32'(bus.dout_valid), 32'h1);
      idle(1);
      chk("t5_ovf_end", 32'(bus.overflow), 32'h0);
      chk("t5_hold2",   32'(bus.dout),     32'h11);
      do_reset();

      // Ready raised on the completing edge: load with no drop and no bubble
      bus.dout_ready = 1'b0;
      send_bits(16'h00A5, 8, 1);
      send_bits(16'h0011, 8, 1);
      send_bits(16'h0011, 7, 1);
      chk("t5b_held", 32'(bus.dout), 32'h11);
      bus.dout_ready = 1'b1;
      send_bits(16'h0000, 1, 1);
      chk("t5b_d22", 32'(bus.dout),       32'h22);
      chk("t5b_v",   32'(bus.dout_valid), 32'h1);
      chk("t5b_sof", 32'(bus.sof),        32'h0);
      chk("t5b_ovf", 32'(bus.overflow),   32'h0);
      bus.dout_ready = 1'b0;
      do_reset();

      // False sync candidates, then abort mid-word and relock
      bus.dout_ready = 1'b1;
      send_bits(16'h005A, 8, 1);
      chk("t6_5a", 32'(bus.locked), 32'h0);
      send_bits(16'h00A4, 8, 1);
      chk("t6_a4", 32'(bus.locked), 32'h0);
      send_bits(16'h0052, 7, 1);
      chk("t6_pre", 32'(bus.locked), 32'h0);
      send_bits(16'h0001, 1, 1);
      chk("t6_lock", 32'(bus.locked), 32'h1);
      send_bits(16'h000F, 4, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_abort", 32'(bus.locked), 32'h0);
      step();
      rst = 1'b0;
      send_bits(16'h00A5, 8, 1);
      send_bits(16'h0077, 8, 1);
      chk("t6_d77",  32'(bus.dout),       32'h77);
      chk("t6_sof",  32'(bus.sof),        32'h1);
      chk("t6_v77",  32'(bus.dout_valid), 32'h1);
      idle(1);
      chk("t6_acc_v", 32'(bus.dout_valid), 32'h0);
      chk("t6_acc_d", 32'(bus.dout),       32'h77);
      chk("t6_acc_s", 32'(bus.sof),        32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
